// File: rtl/stage.sv
// Shared pipeline-stage types: the Decode-facing instruction bundle and fetch controller states.
package stage;

    localparam int STAGE_ADDR_WIDTH    = 30;
    localparam int FETCH_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic                        valid;
        logic [STAGE_ADDR_WIDTH-1:0] addr;
        logic [31:0]                 insn;
    } InsnBundle;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FLUSH
    } FetchState;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, same-cycle push/pop and a whole-queue flush.
// Head data is read straight from storage, so a push becomes visible the cycle after it is written.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign do_push   = push && (!full || pop);
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues credit-limited word fetches and buffers in-order responses for Decode.
// Redirect reloads the PC, empties the output buffer and discards responses still in flight.
module fetch_sequencer
    import stage::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    DEPTH      = FETCH_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-3:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-3:0] redirect_addr,
    input  logic                  out_ready,
    output InsnBundle             out_bundle
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam int CW = $clog2(DEPTH) + 1;

    FetchState   state, state_next;
    logic [WA-1:0] pc;
    logic [CW-1:0] inflight, inflight_next, discard_cnt;
    logic [CW-1:0] addr_count, out_count;
    logic [CW:0]   credit_sum;
    logic          accept, redirect, deliver, credit_ok;
    logic          addr_empty, addr_full, out_empty, out_full;
    logic [WA-1:0] addr_head;
    logic [WA+31:0] out_head;
    logic          unused_fifo_status;

    assign accept     = imem_req_valid && imem_req_ready;
    assign redirect   = redirect_valid && (state != BOOT);
    assign deliver    = imem_rsp_valid && (discard_cnt == '0) && !redirect;
    assign credit_sum = {1'b0, inflight} + {1'b0, out_count};
    assign credit_ok  = credit_sum < (CW+1)'(DEPTH);
    assign imem_req_addr = pc;

    always_comb begin
        inflight_next = inflight;
        case ({accept, imem_rsp_valid})
            2'b10:   inflight_next = inflight + 1'b1;
            2'b01:   inflight_next = inflight - 1'b1;
            default: inflight_next = inflight;
        endcase
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   imem_req_valid = credit_ok && !redirect_valid;
            FLUSH:   if (discard_cnt == '0) state_next = FETCH;
            default: state_next = BOOT;
        endcase
        // Every request still outstanding after a redirect belongs to the old path.
        if (redirect) state_next = (inflight_next != '0) ? FLUSH : FETCH;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= RESET_ADDR[ADDR_WIDTH-1:2];
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            if (redirect) begin
                pc          <= redirect_addr;
                discard_cnt <= inflight_next;
            end else begin
                if (accept) pc <= pc + 1'b1;
                if (imem_rsp_valid && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
            end
        end
    end

    // Pairs each in-order response with the address that requested it, stale or not.
    sync_fifo #(.WIDTH(WA), .DEPTH(DEPTH)) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (pc),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head_data (addr_head),
        .count     (addr_count),
        .empty     (addr_empty),
        .full      (addr_full)
    );

    sync_fifo #(.WIDTH(WA + 32), .DEPTH(DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (deliver),
        .push_data ({addr_head, imem_rsp_data}),
        .pop       (out_bundle.valid && out_ready),
        .flush     (redirect),
        .head_data (out_head),
        .count     (out_count),
        .empty     (out_empty),
        .full      (out_full)
    );

    assign unused_fifo_status = &{1'b0, addr_count, addr_empty, addr_full, out_full};

    always_comb begin
        out_bundle       = '0;
        out_bundle.valid = !out_empty;
        if (!out_empty) begin
            out_bundle.addr = STAGE_ADDR_WIDTH'(out_head[WA+31:32]);
            out_bundle.insn = out_head[31:0];
        end
    end

endmodule
